reg_writeback_arbiter: RTL and testbench
========================================

// Module: reg_writeback_arbiter
// PURPOSE
//   Write-side driver for the 32x32 RegisterFile. Merges ALU results and load
//   results into the file's single write port (BusW/RW/RegWr). ALU results take
//   priority. Colliding load results wait in a small pending FIFO.
//   Sits at the end of the writeback stage, between the pipeline and RegisterFile.
// PARAMETERS
//   PEND_DEPTH  2   pending-load FIFO depth in entries; legal range 1..4.
//   DATA_W      32  datapath width; must match the RegisterFile bus width.
// PORTS
//   Clk       in   1       rising-edge clock
//   Rst       in   1       asynchronous reset, active-low
//   AluValid  in   1       ALU result present this cycle; always accepted, no back-pressure
//   AluRd     in   5       ALU destination register
//   AluData   in   DATA_W  ALU result
//   MemValid  in   1       load result offered
//   MemReady  out  1       load result accepted when MemValid&&MemReady
//   MemRd     in   5       load destination register
//   MemData   in   DATA_W  load data
//   BusW      out  DATA_W  write data to RegisterFile
//   RW        out  5       write address to RegisterFile
//   RegWr     out  1       write enable to RegisterFile
//   Busy      out  1       pending FIFO non-empty
// BEHAVIOUR
//   - Reset (Rst=0, async): BusW=0, RW=0, RegWr=0, Busy=0, FIFO empty.
//     In-flight entries are discarded. MemReady=1 one cycle after Rst deasserts.
//   - All outputs are registered. Latency from acceptance to RegWr is 1 cycle
//     minimum. Writes to the register file land on the next Clk edge.
//   - MemReady = (count < PEND_DEPTH). It is combinational from the registered count only.
//   - Per-cycle selection, evaluated in priority order:
//       1. AluValid: issue the ALU write.
//       2. Else, FIFO non-empty: pop the head and issue it.
//       3. Else, load accepted: issue the load directly (bypasses the FIFO).
//       4. Else: RegWr=0. BusW and RW hold their previous values.
//   - A load accepted in a cycle where it is not issued is pushed to the FIFO tail.
//     Pop and push in the same cycle are legal, including when full.
//   - FIFO drains strictly in order.
//   - States: EMPTY (count=0), PEND (0<count<PEND_DEPTH), FULL (count=PEND_DEPTH).
//     - EMPTY->PEND: push without pop.
//     - PEND->FULL: push without pop.
//     - FULL->PEND: pop without push.
//     - PEND->EMPTY: last pop without push.
//     - Push together with pop: count unchanged.
//   - WAW kill: an ALU write to rd R (R!=0) invalidates every FIFO entry with rd=R.
//     It also invalidates a same-cycle load to rd=R.
//     Reason: the ALU op is younger, so the older load value must not overwrite it.
//     A killed entry is still popped in order, but with RegWr=0. It uses one issue slot.
//   - Register 0: any selected write with rd=0 is consumed with RegWr=0.
//     $0 is never written.
//   - MemValid while MemReady=0: the load is not accepted. The source must hold it.
// CONFIGURATION
//   WB_STATS_EN defined:
//     - Adds output WrCount[31:0]: increments on every cycle with RegWr=1, wraps mod 2^32.
//     - Adds output DropCount[15:0]: increments on each rd=0 drop or WAW kill, saturates at 16'hFFFF.
//     - Both counters reset to 0.
//   WB_STATS_EN undefined: both ports and counters are absent. All other behaviour is identical.
// TESTING
//   1. Reset: Rst=0 mid-stream with 2 FIFO entries -> next cycle RegWr=0, Busy=0.
//      MemReady=1 after release.
//   2. Solo ALU: AluValid, rd=5, data=32'hDEADBEEF -> next cycle RegWr=1, RW=5,
//      BusW=32'hDEADBEEF.
//   3. Collision: ALU rd=3 and load rd=4 in the same cycle.
//      - Cycle+1: write r3.
//      - Cycle+2: write r4.
//      - Busy=1 for exactly one cycle.
//   4. Full: hold AluValid=1 with distinct rds and offer 3 loads.
//      - MemReady=0 after 2 loads are accepted.
//      - Drop AluValid: loads write in order r10, r11, then r12 once it is accepted.
//   5. WAW: load rd=7 pending, then ALU rd=7 data=1.
//      - r7 is written with 1 only; the load's pop has RegWr=0.
//      - DropCount=1 when WB_STATS_EN is defined.
//   6. Zero: ALU rd=0 -> RegWr stays 0. Load rd=0 -> RegWr stays 0 and MemReady is unaffected.

Source files
------------

// File: rtl/reg_writeback_arbiter.sv
// Single write-port driver for the 32x32 register file: ALU results win, colliding loads queue in order.
// Optional WB_STATS_EN adds write and drop counters (WrCount, DropCount).
module reg_writeback_arbiter #(
  parameter int PEND_DEPTH = 2,
  parameter int DATA_W     = 32
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              AluValid,
  input  logic [4:0]        AluRd,
  input  logic [DATA_W-1:0] AluData,
  input  logic              MemValid,
  output logic              MemReady,
  input  logic [4:0]        MemRd,
  input  logic [DATA_W-1:0] MemData,
  output logic [DATA_W-1:0] BusW,
  output logic [4:0]        RW,
  output logic              RegWr,
`ifdef WB_STATS_EN
  output logic [31:0]       WrCount,
  output logic [15:0]       DropCount,
`endif
  output logic              Busy
);

  localparam int CW = $clog2(PEND_DEPTH + 1);
  localparam int PW = (PEND_DEPTH > 1) ? $clog2(PEND_DEPTH) : 1;

  typedef enum logic [1:0] {EMPTY, PEND, FULL} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         count_q, count_d;
  logic [PW-1:0]         rd_ptr_q, wr_ptr_q;
  logic [PEND_DEPTH-1:0] live_q;
  logic [4:0]            q_rd   [PEND_DEPTH];
  logic [DATA_W-1:0]     q_data [PEND_DEPTH];

  logic              accept_p0, kill_p0, pop_p0, push_p0, fifo_ne_p0;
  logic              issue_p0, wr_p0, drop_p0;
  logic [4:0]        rd_p0;
  logic [DATA_W-1:0] data_p0;

  logic              vld_p1;
  logic [4:0]        rw_p1;
  logic [DATA_W-1:0] busw_p1;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(PEND_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign MemReady   = (count_q < CW'(PEND_DEPTH));
  assign Busy       = (state_q != EMPTY);
  assign fifo_ne_p0 = (count_q != '0);
  assign accept_p0  = MemValid && MemReady;
  assign kill_p0    = AluValid && (AluRd != 5'd0);
  assign pop_p0     = !AluValid && fifo_ne_p0;
  assign push_p0    = accept_p0 && (AluValid || fifo_ne_p0);

  // Stage p0: pick one issue slot per cycle (ALU, then queue head, then direct load)
  always_comb begin
    issue_p0 = 1'b0;
    wr_p0    = 1'b0;
    rd_p0    = '0;
    data_p0  = '0;
    if (AluValid) begin
      issue_p0 = 1'b1;
      rd_p0    = AluRd;
      data_p0  = AluData;
      wr_p0    = (AluRd != 5'd0);
    end else if (pop_p0) begin
      issue_p0 = 1'b1;
      rd_p0    = q_rd[rd_ptr_q];
      data_p0  = q_data[rd_ptr_q];
      wr_p0    = live_q[rd_ptr_q] && (q_rd[rd_ptr_q] != 5'd0);
    end else if (accept_p0) begin
      issue_p0 = 1'b1;
      rd_p0    = MemRd;
      data_p0  = MemData;
      wr_p0    = (MemRd != 5'd0);
    end
  end

  assign drop_p0 = issue_p0 && !wr_p0;

  always_comb begin
    count_d = count_q;
    state_d = state_q;
    if (push_p0 && !pop_p0)
      count_d = count_q + CW'(1);
    else if (pop_p0 && !push_p0)
      count_d = count_q - CW'(1);
    if (count_d == '0)
      state_d = EMPTY;
    else if (count_d == CW'(PEND_DEPTH))
      state_d = FULL;
    else
      state_d = PEND;
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q  <= EMPTY;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      live_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (pop_p0)
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (push_p0)
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      // A younger ALU write to the same rd retires any older queued load to it
      for (int i = 0; i < PEND_DEPTH; i++)
        if (kill_p0 && (q_rd[i] == AluRd))
          live_q[i] <= 1'b0;
      if (push_p0)
        live_q[wr_ptr_q] <= !(kill_p0 && (MemRd == AluRd));
    end
  end

  always_ff @(posedge Clk) begin
    if (push_p0) begin
      q_rd[wr_ptr_q]   <= MemRd;
      q_data[wr_ptr_q] <= MemData;
    end
  end

  // Stage p1: registered write port
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      vld_p1  <= 1'b0;
      rw_p1   <= '0;
      busw_p1 <= '0;
    end else begin
      vld_p1 <= wr_p0;
      if (issue_p0) begin
        rw_p1   <= rd_p0;
        busw_p1 <= data_p0;
      end
    end
  end

  assign RegWr = vld_p1;
  assign RW    = rw_p1;
  assign BusW  = busw_p1;

`ifdef WB_STATS_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v, input logic en);
    return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
  endfunction

  logic [31:0] wr_cnt_p1;
  logic [15:0] drop_cnt_p1;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      wr_cnt_p1   <= '0;
      drop_cnt_p1 <= '0;
    end else begin
      wr_cnt_p1   <= wr_cnt_p1 + 32'(wr_p0);
      drop_cnt_p1 <= sat_inc16(drop_cnt_p1, drop_p0);
    end
  end

  assign WrCount   = wr_cnt_p1;
  assign DropCount = drop_cnt_p1;
`endif

endmodule

// File: tb/tb_reg_writeback_arbiter.sv
// Bench for reg_writeback_arbiter: queue-level reference model checked every cycle plus directed literal checks.
module tb_reg_writeback_arbiter;

  localparam int DEPTH = 2;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        AluValid;
  logic [4:0]  AluRd;
  logic [31:0] AluData;
  logic        MemValid;
  logic        MemReady;
  logic [4:0]  MemRd;
  logic [31:0] MemData;
  logic [31:0] BusW;
  logic [4:0]  RW;
  logic        RegWr;
  logic        Busy;
`ifdef WB_STATS_EN
  logic [31:0] WrCount;
  logic [15:0] DropCount;
`endif

  int errors = 0;
  int checks = 0;

  reg_writeback_arbiter #(.PEND_DEPTH(DEPTH), .DATA_W(32)) dut (
    .Clk(Clk), .Rst(Rst),
    .AluValid(AluValid), .AluRd(AluRd), .AluData(AluData),
    .MemValid(MemValid), .MemReady(MemReady), .MemRd(MemRd), .MemData(MemData),
    .BusW(BusW), .RW(RW), .RegWr(RegWr),
`ifdef WB_STATS_EN
    .WrCount(WrCount), .DropCount(DropCount),
`endif
    .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending loads as an ordered queue of {rd, data, live}
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    bit          live;
  } ent_t;

  ent_t        mq[$];
  logic        exp_wr    = 1'b0;
  logic [4:0]  exp_rw    = '0;
  logic [31:0] exp_busw  = '0;
  logic        exp_busy  = 1'b0;
  logic        exp_ready = 1'b1;

  always @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      mq.delete();
      exp_wr    = 1'b0;
      exp_busy  = 1'b0;
      exp_ready = 1'b1;
    end else begin
      bit   acc;
      ent_t h;
      ent_t n;
      acc = MemValid && (mq.size() < DEPTH);
      n.rd = MemRd;
      n.data = MemData;
      n.live = 1'b1;
      if (AluValid && AluRd != 5'd0) begin
        foreach (mq[i]) if (mq[i].rd == AluRd) mq[i].live = 1'b0;
        if (MemRd == AluRd) n.live = 1'b0;
      end
      exp_wr = 1'b0;
      if (AluValid) begin
        exp_wr = (AluRd != 5'd0);
        exp_rw = AluRd;
        exp_busw = AluData;
        if (acc) mq.push_back(n);
      end else if (mq.size() > 0) begin
        h = mq.pop_front();
        exp_wr = h.live && (h.rd != 5'd0);
        exp_rw = h.rd;
        exp_busw = h.data;
        if (acc) mq.push_back(n);
      end else if (acc) begin
        exp_wr = (MemRd != 5'd0);
        exp_rw = MemRd;
        exp_busw = MemData;
      end
      exp_busy  = (mq.size() != 0);
      exp_ready = (mq.size() < DEPTH);
    end
  end

  always @(negedge Clk) begin
    chk("model_regwr", {31'd0, RegWr}, {31'd0, exp_wr});
    chk("model_busy", {31'd0, Busy}, {31'd0, exp_busy});
    chk("model_ready", {31'd0, MemReady}, {31'd0, exp_ready});
    if (exp_wr) begin
      chk("model_rw", {27'd0, RW}, {27'd0, exp_rw});
      chk("model_busw", BusW, exp_busw);
    end
  end

  task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic mv, input logic [4:0] mrd, input logic [31:0] md);
    AluValid = av; AluRd = ard; AluData = ad;
    MemValid = mv; MemRd = mrd; MemData = md;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic cyc();
    @(negedge Clk);
  endtask

  initial begin
    Rst = 1'b0;
    idle();
    repeat (2) cyc();
    Rst = 1'b1;
    cyc();
    chk("init_regwr", {31'd0, RegWr}, 32'd0);
    chk("init_busy", {31'd0, Busy}, 32'd0);
    chk("init_ready", {31'd0, MemReady}, 32'd1);
    chk("init_rw", {27'd0, RW}, 32'd0);
    chk("init_busw", BusW, 32'd0);

    // Solo ALU write
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
    cyc();
    chk("solo_regwr", {31'd0, RegWr}, 32'd1);
    chk("solo_rw", {27'd0, RW}, 32'd5);
    chk("solo_busw", BusW, 32'hDEADBEEF);
    idle();
    cyc();
    chk("solo_after_regwr", {31'd0, RegWr}, 32'd0);

    // ALU and load collide
    drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44);
    cyc();
    chk("coll_rw1", {27'd0, RW}, 32'd3);
    chk("coll_busy1", {31'd0, Busy}, 32'd1);
    idle();
    cyc();
    chk("coll_regwr2", {31'd0, RegWr}, 32'd1);
    chk("coll_rw2", {27'd0, RW}, 32'd4);
    chk("coll_busw2", BusW, 32'h44);
    chk("coll_busy2", {31'd0, Busy}, 32'd0);
    cyc();
    chk("coll_regwr3", {31'd0, RegWr}, 32'd0);

    // Fill the queue behind a stream of ALU writes
    drive(1'b1, 5'd20, 32'h2020, 1'b1, 5'd10, 32'h1010);
    cyc();
    chk("full_ready1", {31'd0, MemReady}, 32'd1);
    drive(1'b1, 5'd21, 32'h2121, 1'b1, 5'd11, 32'h1111);
    cyc();
    chk("full_ready2", {31'd0, MemReady}, 32'd0);
    drive(1'b1, 5'd22, 32'h2222, 1'b1, 5'd12, 32'h1212);
    cyc();
    chk("full_rw22", {27'd0, RW}, 32'd22);
    chk("full_ready3", {31'd0, MemReady}, 32'd0);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'h1212);
    cyc();
    chk("full_rw10", {27'd0, RW}, 32'd10);
    chk("full_busw10", BusW, 32'h1010);
    chk("full_ready4", {31'd0, MemReady}, 32'd1);
    cyc();
    chk("full_rw11", {27'd0, RW}, 32'd11);
    chk("full_busy11", {31'd0, Busy}, 32'd1);
    idle();
    cyc();
    chk("full_rw12", {27'd0, RW}, 32'd12);
    chk("full_busw12", BusW, 32'h1212);
    chk("full_busy12", {31'd0, Busy}, 32'd0);
    cyc();

    // WAW: queued load to r7 overtaken by ALU write to r7
    drive(1'b1, 5'd1, 32'h0101, 1'b1, 5'd7, 32'h77);
    cyc();
    drive(1'b1, 5'd7, 32'd1, 1'b0, 5'd0, 32'd0);
    cyc();
    chk("waw_rw", {27'd0, RW}, 32'd7);
    chk("waw_busw", BusW, 32'd1);
    chk("waw_busy", {31'd0, Busy}, 32'd1);
    idle();
    cyc();
    chk("waw_pop_regwr", {31'd0, RegWr}, 32'd0);
    chk("waw_pop_busy", {31'd0, Busy}, 32'd0);
`ifdef WB_STATS_EN
    chk("waw_dropcount", {16'd0, DropCount}, 32'd1);
    chk("waw_wrcount", WrCount, 32'd11);
`endif

    // Same-cycle WAW on the incoming load
    drive(1'b1, 5'd9, 32'h9, 1'b1, 5'd9, 32'h99);
    cyc();
    chk("waw2_rw", {27'd0, RW}, 32'd9);
    chk("waw2_busw", BusW, 32'h9);
    idle();
    cyc();
    chk("waw2_pop_regwr", {31'd0, RegWr}, 32'd0);

    // Register 0 is never written
    drive(1'b1, 5'd0, 32'hABCD, 1'b0, 5'd0, 32'd0);
    cyc();
    chk("zero_alu_regwr", {31'd0, RegWr}, 32'd0);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h5555);
    cyc();
    chk("zero_ld_regwr", {31'd0, RegWr}, 32'd0);
    chk("zero_ld_ready", {31'd0, MemReady}, 32'd1);
    chk("zero_ld_busy", {31'd0, Busy}, 32'd0);
    idle();
    cyc();

    // Asynchronous reset with two loads pending
    drive(1'b1, 5'd2, 32'h22, 1'b1, 5'd13, 32'h1313);
    cyc();
    drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd14, 32'h1414);
    cyc();
    chk("rst_pre_busy", {31'd0, Busy}, 32'd1);
    chk("rst_pre_ready", {31'd0, MemReady}, 32'd0);
    idle();
    #2 Rst = 1'b0;
    cyc();
    chk("rst_regwr", {31'd0, RegWr}, 32'd0);
    chk("rst_busy", {31'd0, Busy}, 32'd0);
    Rst = 1'b1;
    cyc();
    chk("rst_rel_ready", {31'd0, MemReady}, 32'd1);
    chk("rst_rel_regwr", {31'd0, RegWr}, 32'd0);
    cyc();
    chk("rst_rel_regwr2", {31'd0, RegWr}, 32'd0);
    chk("rst_rel_busy", {31'd0, Busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
